// File: rtl/steer_delay_gen_pkg.sv
// rtl/steer_delay_gen_pkg.sv - shared state encoding and angle breakpoints for the steering-delay generator
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    ACCUM  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int BASE_W = 3;

  // Upper bound (inclusive) of each folded-angle band, base delay 6 down to 0.
  localparam int BP_16 = 16;
  localparam int BP_36 = 36;
  localparam int BP_50 = 50;
  localparam int BP_61 = 61;
  localparam int BP_71 = 71;
  localparam int BP_80 = 80;
  localparam int BP_90 = 90;

endpackage

// File: rtl/steer_delay_gen_if.sv
// rtl/steer_delay_gen_if.sv - angle request / delay bank interface; sweep_en_in present only with STEER_SWEEP_EN
interface steer_delay_gen_if #(
  parameter int NUM_MICS = 4,
  parameter int ANGLE_W  = 8,
  parameter int DELAY_W  = 8
);

  logic [ANGLE_W-1:0]          angle_in;
  logic                        angle_valid_in;
  logic                        angle_ready_out;
  logic [NUM_MICS*DELAY_W-1:0] delays_out;
  logic                        delays_valid_out;
  logic                        angle_clamp_out;
  logic                        busy_out;
`ifdef STEER_SWEEP_EN
  logic                        sweep_en_in;
`endif

  modport master (
    output angle_in,
    output angle_valid_in,
`ifdef STEER_SWEEP_EN
    output sweep_en_in,
`endif
    input  angle_ready_out,
    input  delays_out,
    input  delays_valid_out,
    input  angle_clamp_out,
    input  busy_out
  );

  modport slave (
    input  angle_in,
    input  angle_valid_in,
`ifdef STEER_SWEEP_EN
    input  sweep_en_in,
`endif
    output angle_ready_out,
    output delays_out,
    output delays_valid_out,
    output angle_clamp_out,
    output busy_out
  );

endinterface

// File: rtl/steer_delay_gen_base_lut.sv
// rtl/steer_delay_gen_base_lut.sv - folded angle (0..90 deg) to base inter-mic delay in samples
module steer_base_lut
  import steer_pkg::*;
#(
  parameter int ANGLE_W = 8
) (
  input  logic [ANGLE_W-1:0] fold_in,
  output logic [BASE_W-1:0]  base_out
);

  always_comb begin
    base_out = BASE_W'(0);
    if (fold_in <= ANGLE_W'(BP_16))      base_out = BASE_W'(6);
    else if (fold_in <= ANGLE_W'(BP_36)) base_out = BASE_W'(5);
    else if (fold_in <= ANGLE_W'(BP_50)) base_out = BASE_W'(4);
    else if (fold_in <= ANGLE_W'(BP_61)) base_out = BASE_W'(3);
    else if (fold_in <= ANGLE_W'(BP_71)) base_out = BASE_W'(2);
    else if (fold_in <= ANGLE_W'(BP_80)) base_out = BASE_W'(1);
  end

endmodule

// File: rtl/steer_delay_gen.sv
// rtl/steer_delay_gen.sv - serial per-mic steering-delay accumulator with atomic bank commit
// Optional auto angle sweep enabled by defining STEER_SWEEP_EN.
module steer_delay_gen
  import steer_pkg::*;
#(
  parameter int NUM_MICS   = 4,
  parameter int ANGLE_W    = 8,
  parameter int DELAY_W    = 8,
  parameter int MAX_ANGLE  = 180,
  parameter int SWEEP_STEP = 5
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  steer_delay_gen_if.slave  bus
);

  localparam int                 IDX_W    = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_MICS - 1);
  localparam logic [ANGLE_W-1:0] MAX_A    = ANGLE_W'(MAX_ANGLE);
  localparam logic [ANGLE_W-1:0] TH_90    = ANGLE_W'(BP_90);
  localparam logic [ANGLE_W-1:0] TH_180   = ANGLE_W'(180);

  state_t               state_q, state_d;
  logic [ANGLE_W-1:0]   angle_q, angle_d;
  logic                 clamp_q, clamp_d;
  logic [BASE_W-1:0]    base_q, base_d;
  logic [DELAY_W:0]     acc_q, acc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DELAY_W-1:0]   shadow_q [NUM_MICS];
  logic [DELAY_W-1:0]   shadow_d [NUM_MICS];
  logic [DELAY_W-1:0]   bank_q   [NUM_MICS];
  logic [DELAY_W-1:0]   bank_d   [NUM_MICS];
  logic                 valid_q, valid_d;
  logic                 clamp_out_q, clamp_out_d;

  logic                 req_valid;
  logic [ANGLE_W-1:0]   req_angle;
  logic [ANGLE_W-1:0]   fold;
  logic [BASE_W-1:0]    lut_base;
  logic [IDX_W-1:0]     widx;
  logic [DELAY_W-1:0]   acc_sat;

`ifdef STEER_SWEEP_EN
  logic [ANGLE_W-1:0]   last_q, last_d;
  logic                 started_q, started_d;
  logic [ANGLE_W:0]     sweep_sum;
  logic [ANGLE_W-1:0]   sweep_next;

  // External requests win a tie; the sweep then continues from whatever was served.
  always_comb begin
    sweep_sum  = {1'b0, last_q} + (ANGLE_W+1)'(SWEEP_STEP);
    sweep_next = '0;
    if (started_q && (sweep_sum <= (ANGLE_W+1)'(MAX_ANGLE)))
      sweep_next = sweep_sum[ANGLE_W-1:0];
    req_valid = bus.angle_valid_in | bus.sweep_en_in;
    req_angle = bus.angle_valid_in ? bus.angle_in : sweep_next;
  end
`else
  always_comb begin
    req_valid = bus.angle_valid_in;
    req_angle = bus.angle_in;
  end
`endif

  assign fold = (angle_q > TH_90) ? (TH_180 - angle_q) : angle_q;

  steer_base_lut #(.ANGLE_W(ANGLE_W)) u_base_lut (
    .fold_in  (fold),
    .base_out (lut_base)
  );

  // Steering past broadside mirrors the ramp so the last mic carries zero delay.
  assign widx    = (angle_q > TH_90) ? (LAST_IDX - idx_q) : idx_q;
  assign acc_sat = acc_q[DELAY_W] ? {DELAY_W{1'b1}} : acc_q[DELAY_W-1:0];

  always_comb begin
    state_d     = state_q;
    angle_d     = angle_q;
    clamp_d     = clamp_q;
    base_d      = base_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    bank_d      = bank_q;
    valid_d     = 1'b0;
    clamp_out_d = 1'b0;
`ifdef STEER_SWEEP_EN
    last_d      = last_q;
    started_d   = started_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          angle_d = (req_angle > MAX_A) ? MAX_A : req_angle;
          clamp_d = (req_angle > MAX_A);
          state_d = LOOKUP;
`ifdef STEER_SWEEP_EN
          last_d    = (req_angle > MAX_A) ? MAX_A : req_angle;
          started_d = 1'b1;
`endif
        end
      end
      LOOKUP: begin
        base_d  = lut_base;
        acc_d   = '0;
        idx_d   = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        shadow_d[widx] = acc_sat;
        // Once the carry bit is set the accumulator is pinned, so later mics stay saturated.
        acc_d = acc_q[DELAY_W] ? acc_q
                               : acc_q + {{(DELAY_W+1-BASE_W){1'b0}}, base_q};
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = COMMIT;
      end
      COMMIT: begin
        bank_d      = shadow_q;
        valid_d     = 1'b1;
        clamp_out_d = clamp_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      angle_q     <= '0;
      clamp_q     <= 1'b0;
      base_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '{default: '0};
      bank_q      <= '{default: '0};
      valid_q     <= 1'b0;
      clamp_out_q <= 1'b0;
`ifdef STEER_SWEEP_EN
      last_q      <= '0;
      started_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      angle_q     <= angle_d;
      clamp_q     <= clamp_d;
      base_q      <= base_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      bank_q      <= bank_d;
      valid_q     <= valid_d;
      clamp_out_q <= clamp_out_d;
`ifdef STEER_SWEEP_EN
      last_q      <= last_d;
      started_q   <= started_d;
`endif
    end
  end

  for (genvar k = 0; k < NUM_MICS; k++) begin : g_out
    assign bus.delays_out[k*DELAY_W +: DELAY_W] = bank_q[k];
  end

  assign bus.delays_valid_out = valid_q;
  assign bus.angle_clamp_out  = clamp_out_q;
  assign bus.angle_ready_out  = (state_q == IDLE);
  assign bus.busy_out         = (state_q != IDLE);

endmodule

// File: tb/tb_steer_delay_gen.sv
// tb/tb_steer_delay_gen.sv - directed self-checking bench for steer_delay_gen (4-mic and 64-mic instances)
module tb_steer_delay_gen;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  steer_delay_gen_if #(.NUM_MICS(4),  .ANGLE_W(8), .DELAY_W(8)) bus4 ();
  steer_delay_gen_if #(.NUM_MICS(64), .ANGLE_W(8), .DELAY_W(8)) bus64 ();

  steer_delay_gen #(.NUM_MICS(4), .ANGLE_W(8), .DELAY_W(8), .MAX_ANGLE(180), .SWEEP_STEP(5)) dut4 (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus4)
  );

  steer_delay_gen #(.NUM_MICS(64), .ANGLE_W(8), .DELAY_W(8), .MAX_ANGLE(180), .SWEEP_STEP(5)) dut64 (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Issues one request on the 4-mic DUT and returns cycles from accept to the commit pulse (-1 on timeout).
  task automatic send4(input logic [7:0] a, output int lat);
    @(negedge clk);
    bus4.angle_in       = a;
    bus4.angle_valid_in = 1'b1;
    @(negedge clk);
    bus4.angle_valid_in = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus4.delays_valid_out) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic wait_commit4(output int ok);
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus4.delays_valid_out) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic count_pulses4(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus4.delays_valid_out) n++;
    end
  endtask

`ifdef STEER_SWEEP_EN
  function automatic logic [31:0] model4(input int th_in);
    int th, a, b;
    logic [31:0] r;
    th = (th_in > 180) ? 180 : th_in;
    a  = (th > 90) ? 180 - th : th;
    b  = (a <= 16) ? 6 : (a <= 36) ? 5 : (a <= 50) ? 4 : (a <= 61) ? 3 :
         (a <= 71) ? 2 : (a <= 80) ? 1 : 0;
    r = '0;
    for (int k = 0; k < 4; k++)
      r = r | (32'(((th > 90) ? (3 - k) : k) * b) << (8 * k));
    return r;
  endfunction
`endif

  // Directed vectors: angle, packed {ch3,ch2,ch1,ch0}, clamp pulse.
  int          ang_t [10] = '{0, 135, 90, 200, 16, 17, 61, 62, 81, 100};
  logic [31:0] exp_t [10] = '{32'h120C0600, 32'h0004080C, 32'h00000000, 32'h00060C12, 32'h120C0600,
                              32'h0F0A0500, 32'h09060300, 32'h06040200, 32'h00000000, 32'h00010203};
  logic        clp_t [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int lat;
    int ok;
    int n;
    logic [31:0] held;

    rst_n                = 1'b0;
    bus4.angle_in        = '0;
    bus4.angle_valid_in  = 1'b0;
    bus64.angle_in       = '0;
    bus64.angle_valid_in = 1'b0;
`ifdef STEER_SWEEP_EN
    bus4.sweep_en_in     = 1'b0;
    bus64.sweep_en_in    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_delays", bus4.delays_out, 32'h0);
    check("rst_valid",  32'(bus4.delays_valid_out), 32'd0);
    check("rst_clamp",  32'(bus4.angle_clamp_out), 32'd0);
    check("rst_busy",   32'(bus4.busy_out), 32'd0);
    check("rst_ready",  32'(bus4.angle_ready_out), 32'd1);

    for (int i = 0; i < 10; i++) begin
      send4(8'(ang_t[i]), lat);
      check($sformatf("lat_ang%0d", ang_t[i]), 32'(lat), 32'd6);
      check($sformatf("delays_ang%0d", ang_t[i]), bus4.delays_out, exp_t[i]);
      check($sformatf("clamp_ang%0d", ang_t[i]), 32'(bus4.angle_clamp_out), 32'(clp_t[i]));
      held = bus4.delays_out;
      @(negedge clk);
      check($sformatf("pulse_off_ang%0d", ang_t[i]), 32'(bus4.delays_valid_out), 32'd0);
      check($sformatf("hold_ang%0d", ang_t[i]), bus4.delays_out, held);
    end

    // A request held high while busy must be neither served nor queued.
    @(negedge clk);
    bus4.angle_in       = 8'd36;
    bus4.angle_valid_in = 1'b1;
    @(negedge clk);
    check("busy_flag",  32'(bus4.busy_out), 32'd1);
    check("busy_ready", 32'(bus4.angle_ready_out), 32'd0);
    bus4.angle_in = 8'd80;
    repeat (3) @(negedge clk);
    bus4.angle_valid_in = 1'b0;
    wait_commit4(ok);
    check("busy_commit", 32'(ok), 32'd1);
    check("busy_delays", bus4.delays_out, 32'h0F0A0500);
    count_pulses4(12, n);
    check("busy_not_queued", 32'(n), 32'd0);

    // 64-mic instance: ramp of 6 saturates from channel 43 onward.
    @(negedge clk);
    bus64.angle_in       = 8'd0;
    bus64.angle_valid_in = 1'b1;
    @(negedge clk);
    bus64.angle_valid_in = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus64.delays_valid_out) begin
        lat = c;
        break;
      end
    end
    check("m64_lat",  32'(lat), 32'd66);
    check("m64_ch0",  32'(bus64.delays_out[0*8 +: 8]),  32'd0);
    check("m64_ch1",  32'(bus64.delays_out[1*8 +: 8]),  32'd6);
    check("m64_ch42", 32'(bus64.delays_out[42*8 +: 8]), 32'd252);
    check("m64_ch43", 32'(bus64.delays_out[43*8 +: 8]), 32'd255);
    check("m64_ch63", 32'(bus64.delays_out[63*8 +: 8]), 32'd255);

    // Asynchronous reset in the middle of ACCUM clears the bank before the next edge.
    @(negedge clk);
    bus4.angle_in       = 8'd0;
    bus4.angle_valid_in = 1'b1;
    @(negedge clk);
    bus4.angle_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_delays", bus4.delays_out, 32'h0);
    check("arst_busy",   32'(bus4.busy_out), 32'd0);
    check("arst_ready",  32'(bus4.angle_ready_out), 32'd1);
    check("arst_valid",  32'(bus4.delays_valid_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_rel_ready", 32'(bus4.angle_ready_out), 32'd1);
    count_pulses4(10, n);
    check("arst_discarded", 32'(n), 32'd0);

`ifdef STEER_SWEEP_EN
    begin
      int exp_q[$];
      for (int a = 0; a <= 180; a += 5) exp_q.push_back(a);
      exp_q.push_back(0);
      exp_q.push_back(5);
      exp_q.push_back(10);
      exp_q.push_back(15);
      exp_q.push_back(90);
      exp_q.push_back(95);
      @(negedge clk);
      bus4.sweep_en_in = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
        wait_commit4(ok);
        check($sformatf("sweep%0d_seen", i), 32'(ok), 32'd1);
        check($sformatf("sweep%0d_ang%0d", i, exp_q[i]), bus4.delays_out, model4(exp_q[i]));
        if (i == 40) begin
          bus4.angle_in       = 8'd90;
          bus4.angle_valid_in = 1'b1;
          @(negedge clk);
          bus4.angle_valid_in = 1'b0;
        end
        if (i == exp_q.size() - 1) bus4.sweep_en_in = 1'b0;
      end
      count_pulses4(12, n);
      check("sweep_stopped", 32'(n), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
